// File: rtl/freq_meter_pkg.sv
// Shared state encoding, default constants and sizing helper for the frequency meter.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GATE  = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam int unsigned CLK_HZ      = 50_000_000;
  localparam int unsigned GATE_CYCLES = CLK_HZ;

  // Bits needed to hold cycles-1; never below 1, and $clog2 of a 32-bit value caps at 32.
  function automatic int unsigned gate_cnt_w(input int unsigned cycles);
    return (cycles > 32'd1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/sync_rise.sv
// Two-flop synchronizer plus history flop; flags a rising edge of d.
module sync_rise (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic s1;
  logic s2;
  logic hist;

  // Synchronizer chain and history flop, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      hist <= 1'b0;
    end else begin
      s1   <= d;
      s2   <= s1;
      hist <= s2;
    end
  end

  assign rise = s2 & ~hist;

endmodule

// File: rtl/freq_meter.sv
// Gated rising-edge counter: counts sig_in edges over GATE_CYCLES clocks and latches the result.
module freq_meter #(
  parameter int unsigned CLK_HZ      = freq_meter_pkg::CLK_HZ,
  parameter int unsigned GATE_CYCLES = CLK_HZ,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             en,
  output logic [CNT_W-1:0] freq,
  output logic             freq_valid,
  output logic             ovf,
  output logic             busy
);

  import freq_meter_pkg::*;

  localparam int unsigned      GATE_W    = gate_cnt_w(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t            state;
  state_t            state_n;
  logic [GATE_W-1:0] gate_cnt;
  logic [GATE_W-1:0] gate_cnt_n;
  logic [CNT_W-1:0]  edge_cnt;
  logic [CNT_W-1:0]  edge_cnt_n;
  logic              ovf_pend;
  logic              ovf_pend_n;
  logic [CNT_W-1:0]  freq_n;
  logic              ovf_n;
  logic              freq_valid_n;
  logic              busy_n;
  logic              rise;

  sync_rise u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (sig_in),
    .rise (rise)
  );

  // Next-state, counter and output-register update logic.
  always_comb begin
    state_n      = state;
    gate_cnt_n   = gate_cnt;
    edge_cnt_n   = edge_cnt;
    ovf_pend_n   = ovf_pend;
    freq_n       = freq;
    ovf_n        = ovf;
    freq_valid_n = 1'b0;

    case (state)
      IDLE: begin
        if (en) begin
          state_n    = GATE;
          gate_cnt_n = '0;
          edge_cnt_n = '0;
          ovf_pend_n = 1'b0;
        end
      end

      GATE: begin
        if (!en) begin
          // Abort: partial count is dropped, published result untouched.
          state_n = IDLE;
        end else begin
          gate_cnt_n = gate_cnt + GATE_W'(1);
          if (rise) begin
            if (edge_cnt == CNT_MAX) begin
              ovf_pend_n = 1'b1;
            end else begin
              edge_cnt_n = edge_cnt + CNT_W'(1);
            end
          end
          // Result registers load on LATCH entry so they are visible during LATCH.
          if (gate_cnt == GATE_LAST) begin
            state_n      = LATCH;
            freq_n       = edge_cnt_n;
            ovf_n        = ovf_pend_n;
            freq_valid_n = 1'b1;
          end
        end
      end

      LATCH: begin
        if (en) begin
          state_n    = GATE;
          gate_cnt_n = '0;
          edge_cnt_n = '0;
          ovf_pend_n = 1'b0;
        end else begin
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n == GATE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      ovf_pend   <= 1'b0;
      freq       <= '0;
      freq_valid <= 1'b0;
      ovf        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      gate_cnt   <= gate_cnt_n;
      edge_cnt   <= edge_cnt_n;
      ovf_pend   <= ovf_pend_n;
      freq       <= freq_n;
      freq_valid <= freq_valid_n;
      ovf        <= ovf_n;
      busy       <= busy_n;
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (wide counter / narrow saturating counter) share stimulus
// and are checked against an edge-time model of gated counting.
module tb_freq_meter;

  localparam int GA = 1000;
  localparam int GB = 100;

  typedef struct {
    int     cyc;
    longint freq;
    bit     ovf;
  } pulse_t;

  logic        clk;
  logic        rst;
  logic        en;
  logic        sig;
  logic [31:0] freq_a;
  logic        valid_a;
  logic        ovf_a;
  logic        busy_a;
  logic [3:0]  freq_b;
  logic        valid_b;
  logic        ovf_b;
  logic        busy_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // sig_in generator controls: 0 = low, 1 = square wave, 2 = one-cycle pulses at e1/e2
  int mode   = 0;
  int period = 2;
  int phase  = 0;
  int e1     = -100;
  int e2     = -100;

  int     rise_q[$];
  pulse_t pq_a[$];
  pulse_t pq_b[$];
  longint exp_f[2];
  bit     exp_o[2];
  bit     cur;

  freq_meter #(.CLK_HZ(1000), .GATE_CYCLES(GA), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .sig_in(sig), .en(en),
    .freq(freq_a), .freq_valid(valid_a), .ovf(ovf_a), .busy(busy_a)
  );

  freq_meter #(.CLK_HZ(1000), .GATE_CYCLES(GB), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .sig_in(sig), .en(en),
    .freq(freq_b), .freq_valid(valid_b), .ovf(ovf_b), .busy(busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit sig_at(input int n);
    if (mode == 1) return ((n + phase) % period) < (period / 2);
    if (mode == 2) return (n == e1) || (n == e2);
    return 1'b0;
  endfunction

  // Drive sig_in just after each edge; log the posedge at which each rising edge is consumed
  // (3 cycles later). A reset discards edges still in flight and restarts from a low history.
  initial sig = 1'b0;
  always @(posedge clk) begin
    #1;
    cur = sig_at(cyc);
    if (rst) begin
      while (rise_q.size() > 0 && rise_q[rise_q.size()-1] > cyc)
        rise_q.delete(rise_q.size() - 1);
      if (cur) rise_q.push_back(cyc + 3);
    end else if (cur && !sig) begin
      rise_q.push_back(cyc + 3);
    end
    sig = cur;
  end

  // Record every freq_valid cycle for both instances.
  always @(negedge clk) begin
    pulse_t p;
    if (valid_a) begin
      p.cyc = cyc; p.freq = longint'(freq_a); p.ovf = ovf_a;
      pq_a.push_back(p);
    end
    if (valid_b) begin
      p.cyc = cyc; p.freq = longint'(freq_b); p.ovf = ovf_b;
      pq_b.push_back(p);
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint count_rises(input int lo, input int hi);
    longint n = 0;
    foreach (rise_q[i]) if (rise_q[i] >= lo && rise_q[i] <= hi) n++;
    return n;
  endfunction

  // Gates start one cycle after en is raised at c0 and repeat every g+1 cycles; a gate publishes
  // at posedge t if en held through t, counting edges consumed in [t-g+1, t].
  task automatic check_pulses(input int sel, input int c0, input int stop);
    int     g;
    int     t;
    int     k;
    longint maxv;
    longint n;
    longint ef;
    bit     eo;
    string  nm;
    pulse_t q[$];
    g    = sel ? GB : GA;
    maxv = sel ? 64'd15 : 64'hFFFF_FFFF;
    nm   = sel ? "b" : "a";
    if (sel) begin q = pq_b; pq_b.delete(); end
    else     begin q = pq_a; pq_a.delete(); end
    k = 0;
    t = c0 + g + 1;
    while (t <= stop) begin
      n  = count_rises(t - g + 1, t);
      ef = (n > maxv) ? maxv : n;
      eo = (n > maxv);
      if (k < q.size()) begin
        chk({nm, "_pulse_cyc"}, q[k].cyc, t);
        chk({nm, "_freq"}, q[k].freq, ef);
        chk({nm, "_ovf"}, longint'(q[k].ovf), longint'(eo));
      end
      exp_f[sel] = ef;
      exp_o[sel] = eo;
      k++;
      t += g + 1;
    end
    chk({nm, "_pulse_count"}, q.size(), k);
  endtask

  // en is already high since the negedge after c0; keep it through posedge stop, then check.
  task automatic finish_episode(input int c0, input int len);
    int stop;
    stop = c0 + len;
    while (cyc < stop) @(negedge clk);
    chk("a_busy_at_stop", longint'(busy_a), longint'(((stop - c0 - 1) % (GA + 1)) != GA));
    chk("b_busy_at_stop", longint'(busy_b), longint'(((stop - c0 - 1) % (GB + 1)) != GB));
    en = 1'b0;
    @(negedge clk);
    chk("a_busy_after_drop", longint'(busy_a), 0);
    chk("b_busy_after_drop", longint'(busy_b), 0);
    repeat (5) @(negedge clk);
    check_pulses(0, c0, stop);
    check_pulses(1, c0, stop);
    chk("a_freq_held", longint'(freq_a), exp_f[0]);
    chk("a_ovf_held", longint'(ovf_a), longint'(exp_o[0]));
    chk("b_freq_held", longint'(freq_b), exp_f[1]);
    chk("b_ovf_held", longint'(ovf_b), longint'(exp_o[1]));
  endtask

  task automatic episode(input int len);
    int c0;
    c0 = cyc;
    en = 1'b1;
    finish_episode(c0, len);
  endtask

  // Reset pulse part-way through a gate, then a fresh measurement with en still high.
  task automatic reset_episode(input int at, input int len2);
    int c0;
    int r;
    c0 = cyc;
    en = 1'b1;
    while (cyc < c0 + at) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    r = cyc;
    check_pulses(0, c0, r - 1);
    check_pulses(1, c0, r - 1);
    rst = 1'b0;
    exp_f[0] = 0; exp_o[0] = 1'b0;
    exp_f[1] = 0; exp_o[1] = 1'b0;
    chk("a_freq_after_rst", longint'(freq_a), exp_f[0]);
    chk("a_busy_after_rst", longint'(busy_a), 0);
    chk("a_valid_after_rst", longint'(valid_a), 0);
    chk("b_freq_after_rst", longint'(freq_b), exp_f[1]);
    chk("b_busy_after_rst", longint'(busy_b), 0);
    finish_episode(r, len2);
  endtask

  initial begin
    int pick;
    int len;
    rst = 1'b1;
    en  = 1'b0;
    exp_f[0] = 0; exp_f[1] = 0;
    exp_o[0] = 1'b0; exp_o[1] = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_a_freq", longint'(freq_a), 0);
    chk("rst_a_valid", longint'(valid_a), 0);
    chk("rst_a_ovf", longint'(ovf_a), 0);
    chk("rst_a_busy", longint'(busy_a), 0);
    chk("rst_b_freq", longint'(freq_b), 0);
    chk("rst_b_valid", longint'(valid_b), 0);
    chk("rst_b_ovf", longint'(ovf_b), 0);
    chk("rst_b_busy", longint'(busy_b), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Period-100 square wave, first edge consumed at gate cycle 5, three back-to-back gates.
    period = 100;
    phase  = (100 - ((cyc + 4) % 100)) % 100;
    mode   = 1;
    episode(3 * (GA + 1));

    // Abort at gate cycle ~500.
    episode(501);

    // Reset at gate cycle ~300, then a fresh full gate.
    reset_episode(300, GA + 1);

    // Narrow counter saturation, then a silent gate clears ovf.
    period = 4;
    episode(GB + 1);
    mode = 0;
    repeat (4) @(negedge clk);
    episode(GB + 1);

    // Edges consumed on the first and last gate cycles are counted.
    mode = 2;
    e1 = cyc + 5 - 1;
    e2 = cyc + 5 + GA - 2;
    repeat (5) @(negedge clk);
    episode(GA + 1);

    // Edges consumed on the IDLE->GATE entry cycle and in LATCH are not.
    e1 = cyc + 5 - 2;
    e2 = cyc + 5 + GA - 1;
    repeat (5) @(negedge clk);
    episode(GA + 1);

    // Random periods, phases and en lengths.
    for (int i = 0; i < 6; i++) begin
      mode   = 1;
      period = $urandom_range(2, 300);
      phase  = $urandom_range(0, 299);
      pick   = $urandom_range(0, 2);
      if (pick == 0)      len = GA + 1;
      else if (pick == 1) len = $urandom_range(1, GA);
      else                len = 2 * (GA + 1);
      episode(len);
      repeat ($urandom_range(1, 20)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
